lane_symbol_serializer: RTL and testbench
=========================================

Name: lane_symbol_serializer

Overview:
- Per-lane TX stage directly downstream of the 8b/10b encoder.
- Buffers 10-bit encoded symbols in a small FIFO and shifts each one out one bit per clock, LSB (bit "a") first, on lane_bit_o.
- When the FIFO is empty it inserts a parameterised fill symbol, so the lane never stalls mid-stream.
- One instance per lane, inside the multi-lane TX wrapper.

Parameters:
- SYMBOL_WIDTH, 10, encoded symbol width; the shift period equals this value.
- FIFO_DEPTH, 4, symbol FIFO entries; power of 2, minimum 2.
- FILL_SYMBOL, 10'h17C, symbol sent when the FIFO is empty (K28.5 RD-, bit0 = a).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous reset, active-high
- lane_enable_i  input  1  lane enable; 1 = lane transmitting
- symbol_i  input  SYMBOL_WIDTH  encoded symbol; bit0 is transmitted first
- symbol_valid_i  input  1  symbol_i valid
- symbol_ready_o  output  1  FIFO can accept a symbol
- lane_bit_o  output  1  serial bit to the electrical layer
- lane_bit_valid_o  output  1  lane_bit_o is a real transmitted bit
- symbol_boundary_o  output  1  lane_bit_o is bit0 of a symbol
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- underrun_o  output  1  1-cycle pulse when the stream is starved

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=OFF; FIFO emptied; bit_cnt=0; shift register=0.
  - All outputs are 0 the following cycle: lane_bit_o, lane_bit_valid_o, symbol_boundary_o, fifo_level_o, underrun_o.
  - Reset mid-symbol abandons that symbol immediately; no partial symbol is completed.
- symbol_ready_o:
  - Combinational: lane_enable_i && (fifo_level < FIFO_DEPTH) && !rst_i.
  - It depends on the current level only, so a full FIFO refuses a push even if a pop happens in the same cycle.
- Push: symbol_valid_i && symbol_ready_o at an edge writes symbol_i to the FIFO tail.
- symbol_valid_i while not ready is ignored; the upstream must hold the symbol.
- Simultaneous push and pop: level unchanged, ordering preserved.
- State OFF:
  - lane_bit_valid_o=0, lane_bit_o=0, symbol_boundary_o=0.
  - When lane_enable_i=1 at an edge: go to ACTIVE and load the shift register with the FIFO head (pop) if the FIFO was non-empty before that edge, else with FILL_SYMBOL; bit_cnt=0.
- State ACTIVE:
  - lane_bit_o = shreg[0] and lane_bit_valid_o = 1, both registered.
  - symbol_boundary_o = (bit_cnt==0).
  - Each edge: shreg shifts right by 1 and bit_cnt increments.
  - At the edge where bit_cnt==SYMBOL_WIDTH-1 (symbol end):
    - if lane_enable_i=1: load the next symbol (FIFO head with pop if non-empty before the edge, else FILL_SYMBOL); bit_cnt=0.
    - if lane_enable_i=0: go to OFF and flush the FIFO (level=0).
  - Deasserting lane_enable_i mid-symbol always completes the current symbol; symbol_ready_o=0 during the drain.
- Latency: a symbol pushed into an empty FIFO at edge E while ACTIVE is loaded at the first symbol-end edge strictly after E. Its bit0 appears on lane_bit_o in the cycle following that load.
- underrun_o:
  - Pulses 1 cycle coincident with symbol_boundary_o of a FILL_SYMBOL that directly follows a FIFO-sourced symbol.
  - It does not pulse for consecutive fills, or for the first fill after leaving OFF.
- Output is continuous: no gaps between symbols; lane_bit_valid_o stays high throughout ACTIVE.
- Arithmetic: bit_cnt has width $clog2(SYMBOL_WIDTH) and wraps at SYMBOL_WIDTH-1 (not a power of 2). FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

Test Plan:
- Reset, then enable with an empty FIFO:
  - lane_bit_valid_o rises 1 cycle after enable.
  - Bits 0,0,1,1,1,1,1,0,1,0 repeat every 10 cycles (FILL 10'h17C).
  - symbol_boundary_o asserts every 10th cycle.
  - underrun_o stays 0.
- ACTIVE, single push of 10'h2AA mid-fill:
  - The next symbol after the current fill shows 0,1,0,1,0,1,0,1,0,1.
  - The following fill symbol carries underrun_o=1 on its boundary cycle.
  - fifo_level_o goes 1 then 0.
- Burst of 6 symbols 10'h001..10'h006 with valid held, FIFO_DEPTH=4:
  - symbol_ready_o drops when level reaches 4 and reasserts after a pop.
  - All 6 symbols are serialised in order with no fill between them; no symbol is lost or duplicated.
- Deassert lane_enable_i at bit_cnt=3 of symbol 10'h3FF with 2 symbols queued:
  - The remaining 6 bits of 1 are still sent.
  - Then lane_bit_valid_o=0, fifo_level_o=0, symbol_ready_o=0.
- Assert rst_i at bit_cnt=5 while ACTIVE with level 3:
  - The next cycle shows all outputs 0 and fifo_level_o=0.
  - After re-enable, the first symbol is FILL_SYMBOL.
- Push in the same cycle as enable from OFF:
  - FILL_SYMBOL is sent first, then the pushed symbol at the following boundary (FIFO was empty before the edge).

Source files
------------

// File: rtl/lane_symbol_serializer.sv
`default_nettype none
// ============================================================================
// Module   : lane_symbol_serializer
// Brief    : Per-lane TX serializer; FIFO-buffers encoded symbols and shifts
//            them out LSB first, inserting a fill symbol when starved.
// Revision : 1.0
// ============================================================================
module lane_symbol_serializer #(
   parameter int                      SYMBOL_WIDTH = 10,
   parameter int                      FIFO_DEPTH   = 4,
   parameter logic [SYMBOL_WIDTH-1:0] FILL_SYMBOL  = 10'h17C
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            lane_enable_i,
   input  logic [SYMBOL_WIDTH-1:0]         symbol_i,
   input  logic                            symbol_valid_i,
   output logic                            symbol_ready_o,
   output logic                            lane_bit_o,
   output logic                            lane_bit_valid_o,
   output logic                            symbol_boundary_o,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
   output logic                            underrun_o
);

   localparam int c_cnt_w = $clog2(SYMBOL_WIDTH);
   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam int c_lvl_w = c_ptr_w + 1;

   localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(SYMBOL_WIDTH - 1);
   localparam logic [c_lvl_w-1:0] c_depth    = c_lvl_w'(FIFO_DEPTH);

   localparam logic [0:0] c_st_off    = 1'b0;
   localparam logic [0:0] c_st_active = 1'b1;

   logic [0:0]              r_state;
   logic [0:0]              w_state_next;

   logic [SYMBOL_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]      r_wr_ptr;
   logic [c_ptr_w-1:0]      r_rd_ptr;
   logic [c_lvl_w-1:0]      r_level;

   logic [SYMBOL_WIDTH-1:0] r_shreg;
   logic [c_cnt_w-1:0]      r_bit_cnt;
   logic                    r_cur_from_fifo;
   logic                    r_underrun;

   logic                    w_active;
   logic                    w_sym_end;
   logic                    w_load;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_flush;

   assign w_active  = (r_state == c_st_active);
   assign w_sym_end = w_active && (r_bit_cnt == c_last_bit);
   // A new symbol is loaded on entry to ACTIVE or at a symbol end while enabled.
   assign w_load    = lane_enable_i && (!w_active || w_sym_end);
   assign w_pop     = w_load && (r_level != '0);
   assign w_flush   = w_sym_end && !lane_enable_i;

   assign symbol_ready_o = lane_enable_i && (r_level < c_depth) && !rst_i;
   assign w_push         = symbol_valid_i && symbol_ready_o;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= c_st_off;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_off: begin
            if (lane_enable_i) begin
               w_state_next = c_st_active;
            end
         end
         c_st_active: begin
            if (w_flush) begin
               w_state_next = c_st_off;
            end
         end
         default: w_state_next = c_st_off;
      endcase
   end

   // Output logic
   always_comb begin
      lane_bit_o        = 1'b0;
      lane_bit_valid_o  = 1'b0;
      symbol_boundary_o = 1'b0;
      underrun_o        = 1'b0;
      case (r_state)
         c_st_active: begin
            lane_bit_o        = r_shreg[0];
            lane_bit_valid_o  = 1'b1;
            symbol_boundary_o = (r_bit_cnt == '0);
            underrun_o        = r_underrun;
         end
         default: ;
      endcase
   end

   assign fifo_level_o = r_level;

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= symbol_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_lvl_w'(1);
            2'b01:   r_level <= r_level - c_lvl_w'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Underrun is flagged when a fill directly replaces a FIFO-sourced symbol.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_shreg         <= '0;
         r_bit_cnt       <= '0;
         r_cur_from_fifo <= 1'b0;
         r_underrun      <= 1'b0;
      end else begin
         r_underrun <= 1'b0;
         if (w_load) begin
            r_shreg         <= w_pop ? r_mem[r_rd_ptr] : FILL_SYMBOL;
            r_bit_cnt       <= '0;
            r_cur_from_fifo <= w_pop;
            r_underrun      <= w_active && !w_pop && r_cur_from_fifo;
         end else if (w_active) begin
            r_shreg   <= r_shreg >> 1;
            r_bit_cnt <= w_sym_end ? '0 : r_bit_cnt + c_cnt_w'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lane_symbol_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_symbol_serializer
// Brief    : Directed, table-driven self-checking bench for the lane serializer.
// Revision : 1.0
// ============================================================================
module tb_lane_symbol_serializer;

   localparam logic [9:0] c_fill = 10'h17C;
   localparam logic [9:0] c_data = 10'h2AA;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       vld = 1'b0;
   logic [9:0] sym = '0;

   logic       ready;
   logic       lbit;
   logic       lval;
   logic       bnd;
   logic       und;
   logic [2:0] lvl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lane_symbol_serializer dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .lane_enable_i     (en),
      .symbol_i          (sym),
      .symbol_valid_i    (vld),
      .symbol_ready_o    (ready),
      .lane_bit_o        (lbit),
      .lane_bit_valid_o  (lval),
      .symbol_boundary_o (bnd),
      .fifo_level_o      (lvl),
      .underrun_o        (und)
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic       vld;
      logic [9:0] sym;
      logic [6:0] exp_out;   // {bit, valid, boundary, underrun, level}
      logic       exp_rdy;
   } vec_t;

   vec_t tbl [24];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; vld = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Samples the current negedge as bit0 and the next nine; stays on the last one.
   task automatic get_sym(output logic [9:0] s, output logic und0, output int bad);
      bad  = 0;
      und0 = 1'b0;
      s    = '0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         s[i] = lbit;
         if (lval !== 1'b1) bad++;
         if (bnd !== (i == 0)) bad++;
         if (i == 0) und0 = und;
         else if (und !== 1'b0) bad++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   logic [9:0] s;
   logic       u;
   int         bad;
   logic [9:0] fill_v;
   logic [9:0] data_v;

   // Burst logs
   logic       bit_log [81];
   logic       und_log [81];
   logic       rdy_log [81];
   logic [2:0] lvl_log [81];
   int         next_sym;
   int         und_cnt;
   int         pat_bad;
   int         ones;
   logic [9:0] exp_list [8];

   initial begin
      fill_v = c_fill;
      data_v = c_data;

      // Reset, enable with empty FIFO, single push of 0x2AA during the first fill.
      for (int i = 0; i < 24; i++) begin
         tbl[i] = '{rst: 1'b0, en: 1'b1, vld: 1'b0, sym: 10'h000, exp_out: 7'h00, exp_rdy: 1'b1};
      end
      tbl[0].en = 1'b0;
      tbl[0].exp_rdy = 1'b0;
      for (int i = 2; i < 12; i++) begin
         tbl[i].exp_out = {fill_v[i-2], 1'b1, (i == 2), 1'b0, (i >= 6) ? 3'd1 : 3'd0};
      end
      tbl[5].vld = 1'b1;
      tbl[5].sym = c_data;
      for (int i = 12; i < 22; i++) begin
         tbl[i].exp_out = {data_v[i-12], 1'b1, (i == 12), 1'b0, 3'd0};
      end
      tbl[22].exp_out = {fill_v[0], 1'b1, 1'b1, 1'b1, 3'd0};
      tbl[23].exp_out = {fill_v[1], 1'b1, 1'b0, 1'b0, 3'd0};

      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 24; i++) begin
         if (i > 0) @(negedge clk);
         chk($sformatf("row%0d_outputs", i), 32'({lbit, lval, bnd, und, lvl}), 32'(tbl[i].exp_out));
         rst = tbl[i].rst; en = tbl[i].en; vld = tbl[i].vld; sym = tbl[i].sym;
         #1;
         chk($sformatf("row%0d_ready", i), 32'(ready), 32'(tbl[i].exp_rdy));
      end

      // Burst of six symbols with valid held against a depth-4 FIFO.
      do_reset();
      next_sym = 1; und_cnt = 0; pat_bad = 0;
      for (int k = 0; k <= 80; k++) begin
         if (k > 0) @(negedge clk);
         lvl_log[k] = lvl;
         bit_log[k] = lbit;
         und_log[k] = und;
         if (k >= 1) begin
            if (lval !== 1'b1) pat_bad++;
            if (bnd !== ((k - 1) % 10 == 0)) pat_bad++;
            if (und === 1'b1) und_cnt++;
         end
         en = 1'b1;
         if (next_sym <= 6) begin
            vld = 1'b1;
            sym = 10'(next_sym);
         end else begin
            vld = 1'b0;
         end
         #1;
         rdy_log[k] = ready;
         if (vld && ready) next_sym++;
      end
      vld = 1'b0;
      chk("burst_level_full", 32'(lvl_log[4]), 32'd4);
      chk("burst_ready_full", 32'(rdy_log[4]), 32'd0);
      chk("burst_ready_at_pop_edge", 32'(rdy_log[10]), 32'd0);
      chk("burst_level_after_pop", 32'(lvl_log[11]), 32'd3);
      chk("burst_ready_after_pop", 32'(rdy_log[11]), 32'd1);
      chk("burst_pushed", 32'(next_sym), 32'd7);
      exp_list = '{c_fill, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006, c_fill};
      for (int m = 0; m < 8; m++) begin
         for (int i = 0; i < 10; i++) s[i] = bit_log[1 + 10 * m + i];
         chk($sformatf("burst_sym%0d", m), 32'(s), 32'(exp_list[m]));
      end
      chk("burst_underrun_pos", 32'(und_log[71]), 32'd1);
      chk("burst_underrun_count", 32'(und_cnt), 32'd1);
      chk("burst_valid_boundary", 32'(pat_bad), 32'd0);

      // Disable mid-symbol of 0x3FF with two symbols queued.
      do_reset();
      en = 1'b1; vld = 1'b1; sym = 10'h3FF;
      @(negedge clk);
      sym = 10'h0F0;
      @(negedge clk);
      sym = 10'h00F;
      @(negedge clk);
      vld = 1'b0;
      chk("drain_level3", 32'(lvl), 32'd3);
      repeat (8) @(negedge clk);
      chk("drain_3ff_start", 32'({bnd, lbit, lval}), 32'b111);
      repeat (3) @(negedge clk);
      chk("drain_level2", 32'(lvl), 32'd2);
      en = 1'b0;
      #1;
      chk("drain_ready", 32'(ready), 32'd0);
      ones = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (lbit === 1'b1 && lval === 1'b1) ones++;
      end
      chk("drain_tail_bits", 32'(ones), 32'd6);
      @(negedge clk);
      chk("drain_off_outputs", 32'({lbit, lval, bnd, und, lvl, ready}), 32'd0);

      // Reset mid-symbol with three symbols queued.
      do_reset();
      en = 1'b1; vld = 1'b1; sym = 10'h155;
      @(negedge clk);
      sym = 10'h0AA;
      @(negedge clk);
      sym = 10'h333;
      @(negedge clk);
      vld = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_level3", 32'(lvl), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_outputs", 32'({lbit, lval, bnd, und, lvl, ready}), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_ready_after", 32'(ready), 32'd1);
      @(negedge clk);
      get_sym(s, u, bad);
      chk("rst_first_sym", 32'(s), 32'(c_fill));
      chk("rst_first_und", 32'(u), 32'd0);
      chk("rst_first_shape", 32'(bad), 32'd0);

      // Push in the same cycle as enable from OFF.
      do_reset();
      en = 1'b1; vld = 1'b1; sym = c_data;
      #1;
      chk("same_ready", 32'(ready), 32'd1);
      @(negedge clk);
      vld = 1'b0;
      chk("same_level1", 32'(lvl), 32'd1);
      get_sym(s, u, bad);
      chk("same_sym0", 32'(s), 32'(c_fill));
      chk("same_sym0_shape", 32'({u, 8'(bad)}), 32'd0);
      @(negedge clk);
      chk("same_level0", 32'(lvl), 32'd0);
      get_sym(s, u, bad);
      chk("same_sym1", 32'(s), 32'(c_data));
      chk("same_sym1_shape", 32'({u, 8'(bad)}), 32'd0);
      @(negedge clk);
      get_sym(s, u, bad);
      chk("same_sym2", 32'(s), 32'(c_fill));
      chk("same_sym2_underrun", 32'(u), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
